// File: rtl/fp32_div_issue.sv
// Issue stage in front of the iterative FP32 divider: classifies operands, resolves IEEE special
// cases locally, issues normal/normal pairs to the divider and supervises it with a watchdog.
module fp32_div_issue #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [31:0] QNAN           = 32'h7FC00000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    output logic [31:0] div_divident_o,
    output logic [31:0] div_divisor_o,
    output logic        div_start_o,
    input  logic        div_busy_i,
    input  logic        div_valid_i,
    input  logic [31:0] div_result_i,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic [31:0] result_o,
    output logic [3:0]  flags_o
);

    localparam int unsigned WdogW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WdogW-1:0] WdogLast = WdogW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StClassify, StIssue, StWait, StDone} state_e;

    state_e            state_q, state_d;
    logic [31:0]       a_q, b_q;
    logic [31:0]       div_divident_q, div_divisor_q;
    logic [31:0]       result_q;
    logic [3:0]        flags_q;
    logic [WdogW-1:0]  wdog_q;

    // Exponent 0 covers denormals too: they are flushed to zero.
    logic a_zero, a_maxe, a_inf, a_nan, a_norm;
    logic b_zero, b_maxe, b_inf, b_nan, b_norm;
    logic sign;

    assign a_zero = (a_q[30:23] == 8'h00);
    assign a_maxe = (a_q[30:23] == 8'hFF);
    assign a_inf  = a_maxe && (a_q[22:0] == 23'h0);
    assign a_nan  = a_maxe && (a_q[22:0] != 23'h0);
    assign a_norm = !a_zero && !a_maxe;
    assign b_zero = (b_q[30:23] == 8'h00);
    assign b_maxe = (b_q[30:23] == 8'hFF);
    assign b_inf  = b_maxe && (b_q[22:0] == 23'h0);
    assign b_nan  = b_maxe && (b_q[22:0] != 23'h0);
    assign b_norm = !b_zero && !b_maxe;
    assign sign   = a_q[31] ^ b_q[31];

    logic        byp_hit;
    logic [31:0] byp_result;
    logic [3:0]  byp_flags;

    // Flags are {invalid, div_by_zero, timeout, bypass}; first matching case wins.
    always_comb begin
        byp_hit    = 1'b1;
        byp_result = 32'h0;
        byp_flags  = 4'b0001;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            byp_result = QNAN;
            byp_flags  = 4'b1001;
        end else if (a_norm && b_zero) begin
            byp_result = {sign, 8'hFF, 23'h0};
            byp_flags  = 4'b0101;
        end else if (a_inf) begin
            byp_result = {sign, 8'hFF, 23'h0};
        end else if (a_zero || b_inf) begin
            byp_result = {sign, 31'h0};
        end else begin
            byp_hit = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (req_valid_i) state_d = StClassify;
            StClassify: state_d = byp_hit ? StDone : StIssue;
            StIssue:    if (div_busy_i) state_d = StWait;
            StWait:     if (div_valid_i || (wdog_q == WdogLast)) state_d = StDone;
            StDone:     if (res_ready_i) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready_o = (state_q == StIdle);
        div_start_o = (state_q == StIssue) && !div_busy_i;
        res_valid_o = (state_q == StDone);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q            <= 32'h0;
            b_q            <= 32'h0;
            div_divident_q <= 32'h0;
            div_divisor_q  <= 32'h0;
            result_q       <= 32'h0;
            flags_q        <= 4'h0;
            wdog_q         <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        a_q <= a_i;
                        b_q <= b_i;
                    end
                end
                StClassify: begin
                    if (byp_hit) begin
                        result_q <= byp_result;
                        flags_q  <= byp_flags;
                    end else begin
                        div_divident_q <= a_q;
                        div_divisor_q  <= b_q;
                    end
                end
                StIssue: begin
                    if (div_busy_i) wdog_q <= '0;
                end
                StWait: begin
                    wdog_q <= wdog_q + 1'b1;
                    // A result arriving on the timeout cycle takes priority.
                    if (div_valid_i) begin
                        result_q <= div_result_i;
                        flags_q  <= 4'b0000;
                    end else if (wdog_q == WdogLast) begin
                        result_q <= QNAN;
                        flags_q  <= 4'b0010;
                    end
                end
                StDone: begin
                    if (res_ready_i) begin
                        div_divident_q <= 32'h0;
                        div_divisor_q  <= 32'h0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign div_divident_o = div_divident_q;
    assign div_divisor_o  = div_divisor_q;
    assign result_o       = result_q;
    assign flags_o        = flags_q;

endmodule
